// File: rtl/dense_sequencer.sv
// dense_sequencer: sequences one fully connected layer through a single MAC.
// Buffers IN_LEN input features, then for each output neuron reads the bias,
// walks IN_LEN weights, accumulates, applies optional ReLU and saturation,
// and presents the result on a valid/ready output.
// Optional build macro DENSE_SEQ_PERF_EN adds the perf_stall_cnt port, which
// counts output backpressure cycles.
module dense_sequencer #(
    parameter int IN_LEN    = 100,
    parameter int OUT_LEN   = 100,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40,
    parameter int RELU      = 1,
    localparam int W_AW     = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1,
    localparam int B_AW     = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     w_rd_en,
    output logic [W_AW-1:0]          w_addr,
    input  logic signed [DATA_W-1:0] w_data,
    output logic                     b_rd_en,
    output logic [B_AW-1:0]          b_addr,
    input  logic signed [DATA_W-1:0] b_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy,
    output logic                     done
`ifdef DENSE_SEQ_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam int IN_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam logic [IN_W-1:0] IN_LAST  = IN_W'(IN_LEN - 1);
    localparam logic [B_AW-1:0] OUT_LAST = B_AW'(OUT_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_BIAS  = 3'd2;
    localparam logic [2:0] S_MAC   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_EMIT  = 3'd5;

    // Saturation bounds of the DATA_W output, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [2:0]               state_reg;
    logic [IN_W-1:0]          cnt_reg;
    logic [IN_W-1:0]          k_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [W_AW-1:0]          w_addr_reg;
    logic [B_AW-1:0]          b_addr_reg;  // doubles as the output neuron index
    logic                     done_reg;

    logic signed [DATA_W-1:0] buf_mem [IN_LEN];
    logic signed [DATA_W-1:0] buf_rd_reg;

    logic                       in_fire;
    logic signed [2*DATA_W-1:0] mult;
    logic signed [2*DATA_W-1:0] mult_shifted;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    relu_val;

    assign in_ready  = !reset_n && (state_reg == S_IDLE || state_reg == S_LOAD);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_reg == S_EMIT);
    assign busy      = (state_reg != S_IDLE);
    assign done      = done_reg;
    assign w_rd_en   = (state_reg == S_MAC);
    assign b_rd_en   = (state_reg == S_BIAS);
    assign w_addr    = w_addr_reg;
    assign b_addr    = b_addr_reg;

    // Each product is rescaled individually before it reaches the accumulator.
    assign mult         = buf_rd_reg * w_data;
    assign mult_shifted = mult >>> FRAC_BITS;
    assign prod_ext     = ACC_W'(mult_shifted);
    assign bias_ext     = ACC_W'(b_data);

    // Input buffer write port and registered read port; during MAC k the read
    // register fetches buf[k], which pairs with the weight returned a cycle later.
    always_ff @(posedge clock) begin
        if (in_fire) begin
            buf_mem[cnt_reg] <= in_data;
        end
        if (state_reg == S_MAC) begin
            buf_rd_reg <= buf_mem[k_reg];
        end
    end

    // Output stage: optional ReLU, then clamp to the DATA_W signed range.
    always_comb begin
        relu_val = acc_reg;
        if (RELU != 0 && acc_reg[ACC_W-1]) begin
            relu_val = '0;
        end
        if (relu_val > SAT_MAX) begin
            out_data = SAT_MAX[DATA_W-1:0];
        end else if (relu_val < SAT_MIN) begin
            out_data = SAT_MIN[DATA_W-1:0];
        end else begin
            out_data = relu_val[DATA_W-1:0];
        end
    end

    // Layer sequencing FSM with its counters, addresses and accumulator.
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            k_reg      <= '0;
            acc_reg    <= '0;
            w_addr_reg <= '0;
            b_addr_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_LOAD: begin
                    if (in_fire) begin
                        if (cnt_reg == IN_LAST) begin
                            cnt_reg    <= '0;
                            b_addr_reg <= '0;
                            state_reg  <= S_BIAS;
                        end else begin
                            cnt_reg   <= cnt_reg + IN_W'(1);
                            state_reg <= S_LOAD;
                        end
                    end
                end
                S_BIAS: begin
                    k_reg      <= '0;
                    // Rows are contiguous, so later rows continue from the last address.
                    w_addr_reg <= (b_addr_reg == '0) ? '0 : w_addr_reg + W_AW'(1);
                    state_reg  <= S_MAC;
                end
                S_MAC: begin
                    if (k_reg == '0) begin
                        acc_reg <= bias_ext;
                    end else begin
                        acc_reg <= acc_reg + prod_ext;
                    end
                    if (k_reg == IN_LAST) begin
                        state_reg <= S_DRAIN;
                    end else begin
                        k_reg      <= k_reg + IN_W'(1);
                        w_addr_reg <= w_addr_reg + W_AW'(1);
                    end
                end
                S_DRAIN: begin
                    acc_reg   <= acc_reg + prod_ext;
                    state_reg <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (b_addr_reg == OUT_LAST) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            b_addr_reg <= b_addr_reg + B_AW'(1);
                            state_reg  <= S_BIAS;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DENSE_SEQ_PERF_EN
    logic [31:0] perf_reg;

    // Saturating count of output backpressure cycles, restarted per layer.
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            perf_reg <= '0;
        end else if (in_fire && state_reg == S_IDLE) begin
            perf_reg <= '0;
        end else if (out_valid && !out_ready && perf_reg != 32'hFFFF_FFFF) begin
            perf_reg <= perf_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_reg;
`endif

endmodule

// File: tb/tb_dense_sequencer.sv
// tb_dense_sequencer: directed vectors for dense_sequencer (IN_LEN=4, OUT_LEN=2).
// Two instances share all stimulus and memories: one with ReLU, one without.
// Expected outputs are queued at stimulus time and checked by an output monitor.
module tb_dense_sequencer;

    localparam int IN_LEN  = 4;
    localparam int OUT_LEN = 2;
    localparam int DATA_W  = 16;
    localparam int W_AW    = 3;
    localparam int B_AW    = 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                     reset_n;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_ready;
    logic signed [DATA_W-1:0] w_data;
    logic signed [DATA_W-1:0] b_data;

    logic                     in_ready, w_rd_en, b_rd_en, out_valid, busy, done;
    logic [W_AW-1:0]          w_addr;
    logic [B_AW-1:0]          b_addr;
    logic signed [DATA_W-1:0] out_data;

    logic                     nr_in_ready, nr_w_rd_en, nr_b_rd_en, nr_out_valid, nr_busy, nr_done;
    logic [W_AW-1:0]          nr_w_addr;
    logic [B_AW-1:0]          nr_b_addr;
    logic signed [DATA_W-1:0] nr_out_data;
`ifdef DENSE_SEQ_PERF_EN
    logic [31:0]              perf_stall_cnt, nr_perf_stall_cnt;
`endif

    dense_sequencer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_W(DATA_W),
                      .FRAC_BITS(8), .ACC_W(40), .RELU(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_data(b_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
`ifdef DENSE_SEQ_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    dense_sequencer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_W(DATA_W),
                      .FRAC_BITS(8), .ACC_W(40), .RELU(0)) dut_nr (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(nr_in_ready), .in_data(in_data),
        .w_rd_en(nr_w_rd_en), .w_addr(nr_w_addr), .w_data(w_data),
        .b_rd_en(nr_b_rd_en), .b_addr(nr_b_addr), .b_data(b_data),
        .out_valid(nr_out_valid), .out_ready(out_ready), .out_data(nr_out_data),
        .busy(nr_busy), .done(nr_done)
`ifdef DENSE_SEQ_PERF_EN
        , .perf_stall_cnt(nr_perf_stall_cnt)
`endif
    );

    // Synchronous-read weight and bias ROM models.
    logic signed [DATA_W-1:0] w_mem [8];
    logic signed [DATA_W-1:0] b_mem [2];
    always @(posedge clock) begin
        if (w_rd_en) w_data <= w_mem[w_addr];
        if (b_rd_en) b_data <= b_mem[b_addr];
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int last_acc_cyc = 0;
    int w_exp    = 0;
    int out_idx  = 0;

    logic signed [DATA_W-1:0] in_vec [4];
    logic signed [DATA_W-1:0] exp_q [$];
    logic signed [DATA_W-1:0] exp_nr_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Done pulse counter.
    always @(negedge clock) begin
        if (!reset_n && done) done_cnt++;
    end

    // Weight address walk: 0..7 per layer, restarted by reset.
    always @(negedge clock) begin
        if (reset_n) begin
            w_exp = 0;
        end else if (w_rd_en) begin
            check("w_addr", w_addr, w_exp);
            check("w_addr_nr", nr_w_addr, w_exp);
            w_exp = (w_exp == 7) ? 0 : w_exp + 1;
        end
    end

    // Output monitor: pops the scoreboard on every handshake.
    always @(negedge clock) begin
        logic signed [DATA_W-1:0] e, en;
        if (!reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0 || exp_nr_q.size() == 0) begin
                check("sb_underflow", out_data, 32'sh7fff_ffff);
            end else begin
                e  = exp_q.pop_front();
                en = exp_nr_q.pop_front();
                check("out_data", out_data, e);
                check("out_data_norelu", nr_out_data, en);
                check("out_valid_norelu", nr_out_valid, 1);
                $display("OUT idx=%0d data=%0d exp=%0d norelu=%0d exp=%0d",
                         out_idx, out_data, e, nr_out_data, en);
                out_idx++;
            end
        end
    end

    task automatic set_mem(input logic signed [DATA_W-1:0] w0, input logic signed [DATA_W-1:0] w1,
                           input logic signed [DATA_W-1:0] b0, input logic signed [DATA_W-1:0] b1);
        for (int i = 0; i < 4; i++) begin
            w_mem[i]     = w0;
            w_mem[i + 4] = w1;
        end
        b_mem[0] = b0;
        b_mem[1] = b1;
    endtask

    task automatic set_vec(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b,
                           input logic signed [DATA_W-1:0] c, input logic signed [DATA_W-1:0] d);
        in_vec[0] = a; in_vec[1] = b; in_vec[2] = c; in_vec[3] = d;
    endtask

    task automatic push_exp(input logic signed [DATA_W-1:0] e, input logic signed [DATA_W-1:0] en);
        exp_q.push_back(e);
        exp_nr_q.push_back(en);
    endtask

    // Sends the four input beats; optional idle gaps and a trailing extra beat.
    task automatic load_layer(input bit toggle, input bit extra);
        logic acc;
        int   n;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = in_vec[i];
            n = 0;
            do begin
                @(negedge clock);
                acc = in_ready;
                @(posedge clock); #1;
                n++;
            end while (!acc && n < 50);
            if (!acc) check("in_accept_timeout", 0, 1);
            last_acc_cyc = cyc;
            $display("IN beat=%0d data=%0d", i, in_vec[i]);
            if (toggle && i < 3) begin
                in_valid = 1'b0;
                @(posedge clock); #1;
            end
        end
        if (extra) begin
            in_data = 16'sd999;
            @(negedge clock);
            check("extra_beat_in_ready", in_ready, 0);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic wait_done(input string name);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        check({name, "_done_pulses"}, done_cnt - start, 1);
        check({name, "_sb_empty"}, exp_q.size(), 0);
        check({name, "_done_low"}, done, 0);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int n;
        logic signed [DATA_W-1:0] held;
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        set_mem(16'sd256, -16'sd256, 16'sd0, 16'sd0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_w_rd_en", w_rd_en, 0);
        check("rst_b_rd_en", b_rd_en, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_b_addr", b_addr, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;

        // Nominal: 2560 then 0 (ReLU) / -2560 (no ReLU).
        set_vec(16'sd256, 16'sd512, 16'sd768, 16'sd1024);
        set_mem(16'sd256, -16'sd256, 16'sd0, 16'sd0);
        push_exp(16'sd2560, 16'sd2560);
        push_exp(16'sd0, -16'sd2560);
        load_layer(1'b0, 1'b0);
        wait_done("nominal");

        // Bias and latency: 2560 + 128 = 2688, out_valid 6 edges after last accept.
        set_mem(16'sd256, -16'sd256, 16'sd128, 16'sd0);
        push_exp(16'sd2688, 16'sd2688);
        push_exp(16'sd0, -16'sd2560);
        load_layer(1'b0, 1'b0);
        wait_valid(n);
        check("latency_edges", cyc - last_acc_cyc, IN_LEN + 2);
        wait_done("bias");

        // Saturation: +16776192 clamps to 32767; -16776704 clamps to -32768 / ReLU 0.
        set_vec(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
        set_mem(16'sd32767, -16'sd32768, 16'sd0, 16'sd0);
        push_exp(16'sd32767, 16'sd32767);
        push_exp(16'sd0, -16'sd32768);
        load_layer(1'b0, 1'b0);
        wait_done("saturation");

        // Backpressure: 5 stalled cycles on the first output.
        set_vec(16'sd256, 16'sd512, 16'sd768, 16'sd1024);
        set_mem(16'sd256, -16'sd256, 16'sd0, 16'sd0);
        push_exp(16'sd2560, 16'sd2560);
        push_exp(16'sd0, -16'sd2560);
        out_ready = 1'b0;
        load_layer(1'b0, 1'b0);
        wait_valid(n);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_stable", out_data, held);
            check("bp_in_ready", in_ready, 0);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_in_ready_second", in_ready, 0);
        wait_done("backpressure");
`ifdef DENSE_SEQ_PERF_EN
        check("perf_stall_cnt", perf_stall_cnt, 5);
        check("perf_stall_cnt_nr", nr_perf_stall_cnt, 5);
`endif

        // Input stall: valid toggles, extra beat after the fourth is refused.
        push_exp(16'sd2560, 16'sd2560);
        push_exp(16'sd0, -16'sd2560);
        load_layer(1'b1, 1'b1);
        wait_done("input_stall");

        // Reset during MAC k=2 aborts the layer; a fresh layer then completes.
        load_layer(1'b0, 1'b0);
        repeat (3) begin
            @(posedge clock); #1;
        end
        reset_n = 1'b1;
        @(negedge clock);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_w_rd_en", w_rd_en, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        push_exp(16'sd2560, 16'sd2560);
        push_exp(16'sd0, -16'sd2560);
        load_layer(1'b0, 1'b0);
        wait_done("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
